// File: rtl/shift_issue_stage.sv
// shift_issue_stage
// Decode/issue stage that sits directly in front of the 32-bit barrel shifter.
// Takes R-type instruction words plus register operands over a valid/ready
// handshake, decodes the six MIPS shift instructions and presents registered
// a/b/aluc operands and a destination tag to the shifter. The output register
// and one skid register form a 2-entry queue, so in_ready is a flop and has no
// combinational path from out_ready or in_valid.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is registered)
//   in_instr              32-bit instruction word
//   in_rs, in_rt          register operands
//   out_valid / out_ready downstream handshake
//   out_a                 value to shift (rt)
//   out_b                 shift amount (shamt or rs[4:0])
//   out_aluc              00 = SRA, 01 = SRL, 10 = SLL
//   out_tag               destination register (rd field)
//   illegal               one-cycle pulse after a non-shift word is accepted
//
// Optional feature (macro SHIFT_ISSUE_STATS_EN):
//   issued_cnt            saturating count of output transfers
//   illegal_cnt           saturating count of accepted illegal words
module shift_issue_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [4:0]        out_b,
    output logic [1:0]        out_aluc,
    output logic [TAG_W-1:0]  out_tag,
    output logic              illegal
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [4:0]        b;
        logic [1:0]        aluc;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    localparam logic [1:0] ALUC_SRA = 2'b00;
    localparam logic [1:0] ALUC_SRL = 2'b01;
    localparam logic [1:0] ALUC_SLL = 2'b10;

    state_t state;
    state_t next_state;

    entry_t dec_entry;
    entry_t out_q;
    entry_t skid_q;

    logic dec_legal;
    logic accept;
    logic push;
    logic pop;
    logic load_out;
    logic load_skid;
    logic skid_to_out;

    // Register-number fields of rs/rt and the upper rs bits are not needed;
    // CNT_W is only consumed when the statistics counters are built.
    logic unused_bits;
    assign unused_bits = ^{in_rs[DATA_W-1:5], in_instr[25:16], (CNT_W > 0)};

    // Shift decode. Anything with a non-zero opcode or a funct outside the
    // six shift encodings is illegal; NOP (all zeros) decodes as SLL.
    always_comb begin
        dec_legal     = 1'b0;
        dec_entry.a   = in_rt;
        dec_entry.b   = in_instr[10:6];
        dec_entry.aluc = ALUC_SRA;
        dec_entry.tag = TAG_W'(in_instr[15:11]);
        if (in_instr[31:26] == 6'b000000) begin
            case (in_instr[5:0])
                6'b000000: begin dec_legal = 1'b1; dec_entry.aluc = ALUC_SLL; end
                6'b000010: begin dec_legal = 1'b1; dec_entry.aluc = ALUC_SRL; end
                6'b000011: begin dec_legal = 1'b1; dec_entry.aluc = ALUC_SRA; end
                6'b000100: begin
                    dec_legal      = 1'b1;
                    dec_entry.aluc = ALUC_SLL;
                    dec_entry.b    = in_rs[4:0];
                end
                6'b000110: begin
                    dec_legal      = 1'b1;
                    dec_entry.aluc = ALUC_SRL;
                    dec_entry.b    = in_rs[4:0];
                end
                6'b000111: begin
                    dec_legal      = 1'b1;
                    dec_entry.aluc = ALUC_SRA;
                    dec_entry.b    = in_rs[4:0];
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    assign accept    = in_valid && in_ready;
    assign push      = accept && dec_legal;
    assign out_valid = (state != EMPTY);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // In ONE with a simultaneous push and pop the new word goes straight into
    // the output register. A push into FULL cannot happen because in_ready is
    // low there.
    always_comb begin
        next_state  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    next_state = ONE;
                    load_out   = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_out = 1'b1;
                end else if (push) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    next_state  = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // in_ready is computed from the next state so it is a plain flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b1;
            illegal  <= 1'b0;
        end else begin
            in_ready <= (next_state != FULL);
            illegal  <= accept && !dec_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= dec_entry;
            end else if (skid_to_out) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_entry;
            end
        end
    end

    assign out_a    = out_q.a;
    assign out_b    = out_q.b;
    assign out_aluc = out_q.aluc;
    assign out_tag  = out_q.tag;

`ifdef SHIFT_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt  <= '0;
            illegal_cnt <= '0;
        end else begin
            if (pop && (issued_cnt != '1)) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
            end
            if (accept && !dec_legal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Testbench for shift_issue_stage: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [4:0]  out_b;
    logic [1:0]  out_aluc;
    logic [4:0]  out_tag;
    logic        illegal;
`ifdef SHIFT_ISSUE_STATS_EN
    logic [15:0] issued_cnt;
    logic [15:0] illegal_cnt;
    int unsigned expIssued;
    int unsigned expIllegalCnt;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  aluc;
        logic [4:0]  tag;
    } entry_t;

    entry_t expQ[$];
    logic   expIllegal;
    int     checkCount = 0;
    int     passCount  = 0;

    always #5 clk = ~clk;

    shift_issue_stage #(.DATA_W(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_aluc   (out_aluc),
        .out_tag    (out_tag),
        .illegal    (illegal)
`ifdef SHIFT_ISSUE_STATS_EN
        ,
        .issued_cnt (issued_cnt),
        .illegal_cnt(illegal_cnt)
`endif
    );

    // Instruction table: which R-type functs are shifts, which direction,
    // and whether the amount comes from a register.
    function automatic logic refDecode(input logic [31:0] instr, input logic [31:0] rs,
                                       input logic [31:0] rt, output entry_t e);
        logic       variable;
        logic [1:0] dir;
        e     = '0;
        e.a   = rt;
        e.tag = instr[15:11];
        if (instr[31:26] != 6'd0) return 1'b0;
        case (instr[5:0])
            6'd0: begin dir = 2'b10; variable = 1'b0; end
            6'd2: begin dir = 2'b01; variable = 1'b0; end
            6'd3: begin dir = 2'b00; variable = 1'b0; end
            6'd4: begin dir = 2'b10; variable = 1'b1; end
            6'd6: begin dir = 2'b01; variable = 1'b1; end
            6'd7: begin dir = 2'b00; variable = 1'b1; end
            default: return 1'b0;
        endcase
        e.aluc = dir;
        e.b    = variable ? rs[4:0] : instr[10:6];
        return 1'b1;
    endfunction

    function automatic logic [31:0] shiftWord(input logic [5:0] funct, input logic [4:0] rd,
                                              input logic [4:0] shamt);
        return {6'd0, 5'd3, 5'd4, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [5:0]  legalF [6];
        logic [5:0]  badF [5];
        int          sel;
        legalF = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
        badF   = '{6'd1, 6'd5, 6'd8, 6'd32, 6'd42};
        w      = $urandom();
        sel    = $urandom_range(0, 9);
        if (sel <= 5 || sel == 9) begin
            w[31:26] = 6'd0;
            w[5:0]   = legalF[$urandom_range(0, 5)];
        end else if (sel == 6) begin
            w[31:26] = 6'd0;
            w[5:0]   = badF[$urandom_range(0, 4)];
        end else if (sel == 7) begin
            w[31:26] = 6'($urandom_range(1, 63));
            w[5:0]   = legalF[$urandom_range(0, 5)];
        end else begin
            w = 32'h0000_0000;
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < 2));
        checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
        checkOutput("illegal", 32'(illegal), 32'(expIllegal));
        if (expQ.size() != 0) begin
            checkOutput("out_a", out_a, expQ[0].a);
            checkOutput("out_b", 32'(out_b), 32'(expQ[0].b));
            checkOutput("out_aluc", 32'(out_aluc), 32'(expQ[0].aluc));
            checkOutput("out_tag", 32'(out_tag), 32'(expQ[0].tag));
        end
`ifdef SHIFT_ISSUE_STATS_EN
        checkOutput("issued_cnt", 32'(issued_cnt), expIssued);
        checkOutput("illegal_cnt", 32'(illegal_cnt), expIllegalCnt);
`endif
    endtask

    // Reference model: an in-order queue of at most two legal words.
    initial begin
        expIllegal = 1'b0;
`ifdef SHIFT_ISSUE_STATS_EN
        expIssued     = 0;
        expIllegalCnt = 0;
`endif
        forever begin
            entry_t e;
            logic   legal;
            logic   acc;
            logic   drain;
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                expQ.delete();
                expIllegal = 1'b0;
`ifdef SHIFT_ISSUE_STATS_EN
                expIssued     = 0;
                expIllegalCnt = 0;
`endif
            end else begin
                acc        = in_valid && (expQ.size() < 2);
                legal      = refDecode(in_instr, in_rs, in_rt, e);
                drain      = (expQ.size() != 0) && out_ready;
                expIllegal = acc && !legal;
                if (drain) void'(expQ.pop_front());
                if (acc && legal) expQ.push_back(e);
`ifdef SHIFT_ISSUE_STATS_EN
                if (drain && expIssued < 65535) expIssued++;
                if (acc && !legal && expIllegalCnt < 65535) expIllegalCnt++;
`endif
            end
        end
    end

    // Checks the model at the falling edge, then drives one cycle of inputs.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic rdy);
        @(negedge clk);
        compareModel();
        in_valid  = v;
        in_instr  = instr;
        in_rs     = rs;
        in_rt     = rt;
        out_ready = rdy;
        @(posedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_rs     = '0;
        in_rt     = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_out_a", out_a, 32'd0);
        checkOutput("rst_out_b", 32'(out_b), 32'd0);
        checkOutput("rst_out_aluc", 32'(out_aluc), 32'd0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SRA $2,$3,2 with rt = 0x80000000
        applyStimulus(1'b1, 32'h0003_1083, 32'h0, 32'h8000_0000, 1'b1);
        #1;
        checkOutput("sra_valid", 32'(out_valid), 32'd1);
        checkOutput("sra_a", out_a, 32'h8000_0000);
        checkOutput("sra_b", 32'(out_b), 32'd2);
        checkOutput("sra_aluc", 32'(out_aluc), 32'd0);
        checkOutput("sra_tag", 32'(out_tag), 32'd2);

        // SLLV $2,$4,$5 with rs = 0x25
        applyStimulus(1'b1, 32'h00A4_1004, 32'h0000_0025, 32'h1234_5678, 1'b1);
        #1;
        checkOutput("sllv_b", 32'(out_b), 32'd5);
        checkOutput("sllv_aluc", 32'(out_aluc), 32'd2);
        checkOutput("sllv_a", out_a, 32'h1234_5678);

        // NOP issues as SLL $0,$0,0
        applyStimulus(1'b1, 32'h0000_0000, 32'h0, 32'hDEAD_BEEF, 1'b1);
        #1;
        checkOutput("nop_valid", 32'(out_valid), 32'd1);
        checkOutput("nop_aluc", 32'(out_aluc), 32'd2);
        checkOutput("nop_tag", 32'(out_tag), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("drain_empty", 32'(out_valid), 32'd0);

        // Backpressure: three back-to-back words while stalled
        applyStimulus(1'b1, shiftWord(6'd0, 5'd1, 5'd1), 32'h0, 32'h11, 1'b0);
        applyStimulus(1'b1, shiftWord(6'd2, 5'd2, 5'd2), 32'h0, 32'h22, 1'b0);
        #1;
        checkOutput("bp_ready_low", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, shiftWord(6'd3, 5'd3, 5'd3), 32'h0, 32'h33, 1'b0);
        #1;
        checkOutput("bp_hold_tag", 32'(out_tag), 32'd1);
        applyStimulus(1'b1, shiftWord(6'd3, 5'd3, 5'd3), 32'h0, 32'h33, 1'b1);
        #1;
        checkOutput("bp_order2", 32'(out_tag), 32'd2);
        checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, shiftWord(6'd3, 5'd3, 5'd3), 32'h0, 32'h33, 1'b1);
        #1;
        checkOutput("bp_order3", 32'(out_tag), 32'd3);
        checkOutput("bp_order3_a", out_a, 32'h33);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("bp_drained", 32'(out_valid), 32'd0);

        // Illegal word: ADD $2,$4,$5
        applyStimulus(1'b1, 32'h0085_1020, 32'h1, 32'h2, 1'b1);
        #1;
        checkOutput("ill_pulse", 32'(illegal), 32'd1);
        checkOutput("ill_no_valid", 32'(out_valid), 32'd0);
        checkOutput("ill_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("ill_one_cycle", 32'(illegal), 32'd0);

        // Asynchronous reset while FULL
        applyStimulus(1'b1, shiftWord(6'd6, 5'd7, 5'd0), 32'h9, 32'h77, 1'b0);
        applyStimulus(1'b1, shiftWord(6'd7, 5'd8, 5'd0), 32'hA, 32'h88, 1'b0);
        #1;
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        checkOutput("full_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("no_stale", 32'(out_valid), 32'd0);

        // Randomized traffic
        repeat (300) begin
            applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom(), $urandom(),
                          $urandom_range(0, 9) < 6);
        end
        repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        compareModel();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
